// File: rtl/park_pkg.sv
// Shared definitions for the parking-lot occupancy manager: sizes, FSM states,
// and the token cipher used on both the entry and exit sides.
package park_pkg;

  localparam int unsigned NUM_SPACES = 8;
  localparam int unsigned SPACE_W    = 3;
  localparam int unsigned COUNT_W    = 4;
  localparam int unsigned GATE_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALLOC = 2'd1,
    ST_GATE  = 2'd2
  } park_state_e;

  // Token cipher is a plain XOR, so encode and decrypt are the same operation.
  function automatic logic [SPACE_W-1:0] token_encode(
    input logic [SPACE_W-1:0] space,
    input logic [SPACE_W-1:0] pattern
  );
    return space ^ pattern;
  endfunction

  function automatic logic [SPACE_W-1:0] decrypt(
    input logic [SPACE_W-1:0] token,
    input logic [SPACE_W-1:0] pattern
  );
    return token ^ pattern;
  endfunction

  function automatic logic [COUNT_W-1:0] popcount(
    input logic [NUM_SPACES-1:0] vec
  );
    logic [COUNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < int'(NUM_SPACES); i++) begin
      cnt = cnt + COUNT_W'(vec[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/free_space_finder.sv
// Lowest-index free space priority encoder over the occupancy vector.
module free_space_finder
  import park_pkg::*;
(
  input  logic [NUM_SPACES-1:0] occupancy,
  output logic [SPACE_W-1:0]    free_idx_c,
  output logic                  all_full_c
);

  // Scan from the top so the lowest zero bit wins.
  always_comb begin
    free_idx_c = '0;
    all_full_c = 1'b1;
    for (int i = int'(NUM_SPACES) - 1; i >= 0; i--) begin
      if (!occupancy[i]) begin
        free_idx_c = SPACE_W'(i);
        all_full_c = 1'b0;
      end
    end
  end

endmodule

// File: rtl/park_lot_manager.sv
// Occupancy owner for the 8-space lot: allocates spaces and drives the entry
// gate, and frees spaces reported by the exit side.
module park_lot_manager
  import park_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enter,
  input  logic [SPACE_W-1:0]    pattern,
  input  logic                  exit,
  input  logic [NUM_SPACES-1:0] park_location,
  output logic [SPACE_W-1:0]    token,
  output logic                  token_valid,
  output logic                  gate_open,
  output logic                  reject,
  output logic                  exit_error,
  output logic [NUM_SPACES-1:0] occupancy,
  output logic [COUNT_W-1:0]    free_count,
  output logic                  full,
  output logic                  busy
);

  park_state_e             state_q, state_d;
  logic [SPACE_W-1:0]      pattern_q, pattern_d;
  logic [GATE_W-1:0]       gate_cnt_q, gate_cnt_d;
  logic [NUM_SPACES-1:0]   occ_q, occ_d;
  logic [SPACE_W-1:0]      token_q, token_d;
  logic                    token_valid_q, token_valid_d;
  logic                    gate_open_q, gate_open_d;
  logic                    reject_q, reject_d;
  logic                    exit_error_q, exit_error_d;
  logic [COUNT_W-1:0]      free_count_q, free_count_d;
  logic                    full_q, full_d;
  logic                    busy_q, busy_d;

  logic [SPACE_W-1:0]      free_idx_c;
  logic                    all_full_c;
  logic                    exit_legal_c;
  logic [NUM_SPACES-1:0]   alloc_set_c;
  logic [NUM_SPACES-1:0]   exit_clr_c;

  free_space_finder u_finder (
    .occupancy  (occ_q),
    .free_idx_c (free_idx_c),
    .all_full_c (all_full_c)
  );

  // Exit is legal only for a single, currently occupied space (pre-edge view).
  assign exit_legal_c = exit && $onehot(park_location) && (|(park_location & occ_q));

  always_comb begin
    state_d       = state_q;
    pattern_d     = pattern_q;
    gate_cnt_d    = gate_cnt_q;
    token_d       = token_q;
    token_valid_d = 1'b0;
    gate_open_d   = gate_open_q;
    reject_d      = 1'b0;
    exit_error_d  = 1'b0;
    alloc_set_c   = '0;
    exit_clr_c    = '0;

    if (exit) begin
      if (exit_legal_c) begin
        exit_clr_c = park_location;
      end else begin
        exit_error_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (enter) begin
          pattern_d = pattern;
          state_d   = ST_ALLOC;
        end
      end
      ST_ALLOC: begin
        if (all_full_c) begin
          reject_d = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          alloc_set_c   = NUM_SPACES'(1) << free_idx_c;
          token_d       = token_encode(free_idx_c, pattern_q);
          token_valid_d = 1'b1;
          gate_cnt_d    = GATE_W'(GATE_CYCLES);
          gate_open_d   = 1'b1;
          state_d       = ST_GATE;
        end
      end
      ST_GATE: begin
        gate_cnt_d = gate_cnt_q - GATE_W'(1);
        if (gate_cnt_q == GATE_W'(1)) begin
          gate_open_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        gate_open_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase

    // A just-allocated bit is never in exit_clr_c: it was clear before the edge.
    occ_d        = (occ_q | alloc_set_c) & ~exit_clr_c;
    free_count_d = COUNT_W'(NUM_SPACES) - popcount(occ_d);
    full_d       = &occ_d;
    busy_d       = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      pattern_q     <= '0;
      gate_cnt_q    <= '0;
      occ_q         <= '0;
      token_q       <= '0;
      token_valid_q <= 1'b0;
      gate_open_q   <= 1'b0;
      reject_q      <= 1'b0;
      exit_error_q  <= 1'b0;
      free_count_q  <= COUNT_W'(NUM_SPACES);
      full_q        <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pattern_q     <= pattern_d;
      gate_cnt_q    <= gate_cnt_d;
      occ_q         <= occ_d;
      token_q       <= token_d;
      token_valid_q <= token_valid_d;
      gate_open_q   <= gate_open_d;
      reject_q      <= reject_d;
      exit_error_q  <= exit_error_d;
      free_count_q  <= free_count_d;
      full_q        <= full_d;
      busy_q        <= busy_d;
    end
  end

  assign token       = token_q;
  assign token_valid = token_valid_q;
  assign gate_open   = gate_open_q;
  assign reject      = reject_q;
  assign exit_error  = exit_error_q;
  assign occupancy   = occ_q;
  assign free_count  = free_count_q;
  assign full        = full_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_park_lot_manager.sv
// Self-checking bench for park_lot_manager: vector table, directed corner
// sequences and a randomized run against a timeline-based reference model.
module tb_park_lot_manager;

  localparam int G = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       enter;
  logic [2:0] pattern;
  logic       exit;
  logic [7:0] park_location;
  logic [2:0] token;
  logic       token_valid, gate_open, reject, exit_error, full, busy;
  logic [7:0] occupancy;
  logic [3:0] free_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  park_lot_manager #(.GATE_CYCLES(G)) dut (
    .clk           (clk),
    .reset         (reset),
    .enter         (enter),
    .pattern       (pattern),
    .exit          (exit),
    .park_location (park_location),
    .token         (token),
    .token_valid   (token_valid),
    .gate_open     (gate_open),
    .reject        (reject),
    .exit_error    (exit_error),
    .occupancy     (occupancy),
    .free_count    (free_count),
    .full          (full),
    .busy          (busy)
  );

  typedef struct {
    logic       rst, en;
    logic [2:0] pat;
    logic       ex;
    logic [7:0] loc;
    logic       tv;
    logic [2:0] tok;
    logic       gate, rej, err;
    logic [7:0] occ;
    logic [3:0] free;
    logic       full, busy;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; enter = 1'b0; exit = 1'b0; park_location = '0; pattern = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    chk("wait_idle_bound", 32'(busy), 32'd0);
  endtask

  // Full entry transaction; returns the token seen on the allocation edge.
  task automatic do_entry(input logic [2:0] pat, output logic tv, output logic [2:0] tok);
    enter = 1'b1; pattern = pat;
    tick();
    enter = 1'b0;
    tick();
    tv  = token_valid;
    tok = token;
    wait_idle();
  endtask

  // Random-phase reference model state
  logic [7:0] m_occ, m_alloc, m_clr, r_loc;
  logic [2:0] m_pat, m_tok;
  int         c0, next_accept, g_from, g_to, idx;
  logic       e_tv, e_rej, e_err, e_gate, e_busy, r_en, r_ex;
  logic [2:0] r_pat;
  logic       h_tv;
  logic [2:0] h_tok;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    //          rst en pat ex  loc    tv tok gate rej err occ   free full busy
    vecs[0]  = '{1, 0, 3'd0, 0, 8'h00, 0, 3'd0, 0, 0, 0, 8'h00, 4'd8, 0, 0};
    vecs[1]  = '{0, 1, 3'd5, 0, 8'h00, 0, 3'd0, 0, 0, 0, 8'h00, 4'd8, 0, 1};
    vecs[2]  = '{0, 0, 3'd0, 0, 8'h00, 1, 3'd5, 1, 0, 0, 8'h01, 4'd7, 0, 1};
    vecs[3]  = '{0, 0, 3'd0, 0, 8'h00, 0, 3'd0, 1, 0, 0, 8'h01, 4'd7, 0, 1};
    vecs[4]  = '{0, 0, 3'd0, 0, 8'h00, 0, 3'd0, 1, 0, 0, 8'h01, 4'd7, 0, 1};
    vecs[5]  = '{0, 0, 3'd0, 0, 8'h00, 0, 3'd0, 1, 0, 0, 8'h01, 4'd7, 0, 1};
    vecs[6]  = '{0, 0, 3'd0, 0, 8'h00, 0, 3'd0, 0, 0, 0, 8'h01, 4'd7, 0, 0};
    vecs[7]  = '{0, 0, 3'd0, 1, 8'h00, 0, 3'd0, 0, 0, 1, 8'h01, 4'd7, 0, 0};
    vecs[8]  = '{0, 0, 3'd0, 1, 8'h11, 0, 3'd0, 0, 0, 1, 8'h01, 4'd7, 0, 0};
    vecs[9]  = '{0, 0, 3'd0, 1, 8'h02, 0, 3'd0, 0, 0, 1, 8'h01, 4'd7, 0, 0};
    vecs[10] = '{0, 0, 3'd0, 1, 8'h01, 0, 3'd0, 0, 0, 0, 8'h00, 4'd8, 0, 0};
    vecs[11] = '{0, 1, 3'd2, 1, 8'h01, 0, 3'd0, 0, 0, 1, 8'h00, 4'd8, 0, 1};
    vecs[12] = '{0, 1, 3'd6, 0, 8'h00, 1, 3'd2, 1, 0, 0, 8'h01, 4'd7, 0, 1};
    vecs[13] = '{0, 1, 3'd7, 0, 8'h00, 0, 3'd0, 1, 0, 0, 8'h01, 4'd7, 0, 1};
    vecs[14] = '{0, 0, 3'd0, 0, 8'h00, 0, 3'd0, 1, 0, 0, 8'h01, 4'd7, 0, 1};
    vecs[15] = '{0, 0, 3'd0, 0, 8'h00, 0, 3'd0, 1, 0, 0, 8'h01, 4'd7, 0, 1};
    vecs[16] = '{0, 0, 3'd0, 0, 8'h00, 0, 3'd0, 0, 0, 0, 8'h01, 4'd7, 0, 0};
    vecs[17] = '{0, 0, 3'd0, 0, 8'h00, 0, 3'd0, 0, 0, 0, 8'h01, 4'd7, 0, 0};

    reset = 1'b1; enter = 1'b0; exit = 1'b0; park_location = '0; pattern = '0;
    tick();

    for (int i = 0; i < 18; i++) begin
      reset = vecs[i].rst; enter = vecs[i].en; pattern = vecs[i].pat;
      exit = vecs[i].ex; park_location = vecs[i].loc;
      tick();
      chk($sformatf("vec%0d.token_valid", i), 32'(token_valid), 32'(vecs[i].tv));
      if (vecs[i].tv) chk($sformatf("vec%0d.token", i), 32'(token), 32'(vecs[i].tok));
      chk($sformatf("vec%0d.gate_open", i), 32'(gate_open), 32'(vecs[i].gate));
      chk($sformatf("vec%0d.reject", i), 32'(reject), 32'(vecs[i].rej));
      chk($sformatf("vec%0d.exit_error", i), 32'(exit_error), 32'(vecs[i].err));
      chk($sformatf("vec%0d.occupancy", i), 32'(occupancy), 32'(vecs[i].occ));
      chk($sformatf("vec%0d.free_count", i), 32'(free_count), 32'(vecs[i].free));
      chk($sformatf("vec%0d.full", i), 32'(full), 32'(vecs[i].full));
      chk($sformatf("vec%0d.busy", i), 32'(busy), 32'(vecs[i].busy));
    end

    // Fill the lot, then a 9th entry is rejected.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      do_entry(3'd0, h_tv, h_tok);
      chk($sformatf("fill%0d.token_valid", k), 32'(h_tv), 32'd1);
      chk($sformatf("fill%0d.token", k), 32'(h_tok), 32'(k));
    end
    chk("fill.full", 32'(full), 32'd1);
    chk("fill.occupancy", 32'(occupancy), 32'hFF);
    chk("fill.free_count", 32'(free_count), 32'd0);
    enter = 1'b1; pattern = 3'd0;
    tick();
    enter = 1'b0;
    tick();
    chk("ninth.reject", 32'(reject), 32'd1);
    chk("ninth.token_valid", 32'(token_valid), 32'd0);
    chk("ninth.gate_open", 32'(gate_open), 32'd0);
    chk("ninth.occupancy", 32'(occupancy), 32'hFF);
    tick();
    chk("ninth.busy_after", 32'(busy), 32'd0);
    chk("ninth.reject_pulse", 32'(reject), 32'd0);
    chk("ninth.gate_after", 32'(gate_open), 32'd0);

    // Free space 3 from a full lot, then reallocate it with pattern 3.
    exit = 1'b1; park_location = 8'h08;
    tick();
    exit = 1'b0; park_location = '0;
    chk("free3.occupancy", 32'(occupancy), 32'hF7);
    chk("free3.free_count", 32'(free_count), 32'd1);
    chk("free3.full", 32'(full), 32'd0);
    chk("free3.exit_error", 32'(exit_error), 32'd0);
    do_entry(3'd3, h_tv, h_tok);
    chk("realloc3.token_valid", 32'(h_tv), 32'd1);
    chk("realloc3.token", 32'(h_tok), 32'd0);
    chk("realloc3.occupancy", 32'(occupancy), 32'hFF);

    // Exit of space 0 during the ALLOC cycle with occupancy 0F.
    do_reset();
    for (int k = 0; k < 4; k++) do_entry(3'd0, h_tv, h_tok);
    chk("simul.pre_occ", 32'(occupancy), 32'h0F);
    enter = 1'b1; pattern = 3'd1;
    tick();
    enter = 1'b0; exit = 1'b1; park_location = 8'h01;
    tick();
    exit = 1'b0; park_location = '0;
    chk("simul.token_valid", 32'(token_valid), 32'd1);
    chk("simul.token", 32'(token), 32'd5);
    chk("simul.occupancy", 32'(occupancy), 32'h1E);
    chk("simul.free_count", 32'(free_count), 32'd4);
    chk("simul.exit_error", 32'(exit_error), 32'd0);
    wait_idle();

    // Exit addressing the very space being allocated is an error.
    enter = 1'b1; pattern = 3'd0;
    tick();
    enter = 1'b0; exit = 1'b1; park_location = 8'h01;
    tick();
    exit = 1'b0; park_location = '0;
    chk("same.exit_error", 32'(exit_error), 32'd1);
    chk("same.token_valid", 32'(token_valid), 32'd1);
    chk("same.token", 32'(token), 32'd0);
    chk("same.occupancy", 32'(occupancy), 32'h1F);
    wait_idle();

    // Reset in the middle of the gate period.
    do_reset();
    enter = 1'b1; pattern = 3'd0;
    tick();
    enter = 1'b0;
    tick();
    chk("rstgate.gate_open", 32'(gate_open), 32'd1);
    enter = 1'b1; pattern = 3'd6;
    tick();
    chk("rstgate.ignored_tv", 32'(token_valid), 32'd0);
    chk("rstgate.ignored_occ", 32'(occupancy), 32'h01);
    enter = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstgate.gate_open_drop", 32'(gate_open), 32'd0);
    chk("rstgate.occupancy", 32'(occupancy), 32'h00);
    chk("rstgate.free_count", 32'(free_count), 32'd8);
    chk("rstgate.busy", 32'(busy), 32'd0);
    tick();
    chk("rstgate.busy_after", 32'(busy), 32'd0);
    chk("rstgate.gate_after", 32'(gate_open), 32'd0);

    // Randomized run against the timeline model.
    do_reset();
    m_occ = '0; c0 = -1000; next_accept = 0; g_from = -10; g_to = -11; m_pat = '0; m_tok = '0;
    for (int c = 0; c < 2000; c++) begin
      r_en  = ($urandom % 2) == 0;
      r_pat = 3'($urandom % 8);
      r_ex  = ($urandom % 4) == 0;
      r_loc = 8'($urandom % 256);
      if (($urandom % 2) == 0) begin
        idx = int'($urandom % 8);
        for (int j = 0; j < 8; j++) begin
          if (m_occ[(idx + j) % 8]) begin
            r_loc = 8'(1) << ((idx + j) % 8);
            break;
          end
        end
      end else if (($urandom % 2) == 0) begin
        r_loc = 8'(1) << ($urandom % 8);
      end
      enter = r_en; pattern = r_pat; exit = r_ex; park_location = r_loc;

      e_tv = 1'b0; e_rej = 1'b0; e_err = 1'b0; m_alloc = '0; m_clr = '0;
      if (c == c0 + 1) begin
        if (m_occ == 8'hFF) begin
          e_rej = 1'b1;
          next_accept = c + 1;
        end else begin
          idx = 0;
          for (int i = 7; i >= 0; i--) if (!m_occ[i]) idx = i;
          m_alloc = 8'(1) << idx;
          e_tv = 1'b1;
          m_tok = 3'(idx) ^ m_pat;
          g_from = c; g_to = c + G - 1;
          next_accept = c + G + 1;
        end
      end
      if (r_en && c >= next_accept) begin
        c0 = c; m_pat = r_pat; next_accept = c + 1000;
      end
      if (r_ex) begin
        if ($countones(r_loc) == 1 && (m_occ & r_loc) != 0) m_clr = r_loc;
        else e_err = 1'b1;
      end
      m_occ  = (m_occ | m_alloc) & ~m_clr;
      e_gate = (c >= g_from) && (c <= g_to);
      e_busy = (c >= c0) && (c <= next_accept - 2);

      tick();
      chk($sformatf("rnd%0d.token_valid", c), 32'(token_valid), 32'(e_tv));
      if (e_tv) chk($sformatf("rnd%0d.token", c), 32'(token), 32'(m_tok));
      chk($sformatf("rnd%0d.reject", c), 32'(reject), 32'(e_rej));
      chk($sformatf("rnd%0d.exit_error", c), 32'(exit_error), 32'(e_err));
      chk($sformatf("rnd%0d.gate_open", c), 32'(gate_open), 32'(e_gate));
      chk($sformatf("rnd%0d.busy", c), 32'(busy), 32'(e_busy));
      chk($sformatf("rnd%0d.occupancy", c), 32'(occupancy), 32'(m_occ));
      chk($sformatf("rnd%0d.free_count", c), 32'(free_count), 32'(8 - $countones(m_occ)));
      chk($sformatf("rnd%0d.full", c), 32'(full), 32'(m_occ == 8'hFF));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
